// File: rtl/ping_pong_bank_buffer_pkg.sv
// Shared types and elaboration helpers for the ping-pong bank buffer.
//   state_t   : ownership FSM states
//   bandwidth : bits per bank word (blocks * block width)
//   aw        : address width for a given depth (at least 1 bit)
package ping_pong_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        READING   = 2'd1,
        FULL_WAIT = 2'd2
    } state_t;

    function automatic int bandwidth(input int block_count, input int block_width);
        return block_count * block_width;
    endfunction

    function automatic int aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ping_pong_bank_buffer_ram.sv
// bank_sdp_ram: single-clock simple dual-port RAM for one bank of one copy.
//   clk, reset          : clock; reset clears only the read output registers
//   we/waddr/wdata      : write port
//   wblock_en           : per-block write mask
//   re/raddr            : read port; rdata changes only after an enabled read
//   rdata               : read data, READ_LATENCY (1 or 2) cycles after re
module bank_sdp_ram
    import ping_pong_pkg::*;
#(
    parameter int DEPTH            = 512,
    parameter int BLOCK_COUNT      = 4,
    parameter int BLOCK_DATA_WIDTH = 32,
    parameter int READ_LATENCY     = 1,
    localparam int WIDTH = bandwidth(BLOCK_COUNT, BLOCK_DATA_WIDTH),
    localparam int AW    = aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [BLOCK_COUNT-1:0] wblock_en,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic [WIDTH-1:0]       rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < BLOCK_COUNT; b++) begin
                if (wblock_en[b]) begin
                    mem[waddr][b*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH] <=
                        wdata[b*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH];
                end
            end
        end
    end

    // Output registers are enabled by the read strobe so data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            q1 <= '0;
        end else if (re) begin
            q1 <= mem[raddr];
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic             re_d;
        logic [WIDTH-1:0] q2;

        always_ff @(posedge clk) begin
            if (reset) begin
                re_d <= 1'b0;
                q2   <= '0;
            end else begin
                re_d <= re;
                if (re_d) begin
                    q2 <= q1;
                end
            end
        end

        assign rdata = q2;
    end else begin : g_direct
        assign rdata = q1;
    end

endmodule

// File: rtl/ping_pong_bank_buffer.sv
// ping_pong_bank_buffer: double-buffered multi-bank line/frame store.
// The writer fills copy wr_sel while the reader drains copy ~wr_sel;
// ownership swaps on the commit/release handshake.
//   wr_en/wr_addr/wr_data/wr_block_en : per-bank writes (flat buses)
//   wr_commit, wr_ready, wr_drop      : writer handshake / ignored-op pulse
//   rd_en/rd_addr, rd_release         : reads of all banks / reader handshake
//   rd_avail, rd_data, rd_valid       : reader status and returned data
module ping_pong_bank_buffer
    import ping_pong_pkg::*;
#(
    parameter int ADDRESS_DEPTH    = 512,
    parameter int BANK_COUNT       = 3,
    parameter int BLOCK_COUNT      = 4,
    parameter int BLOCK_DATA_WIDTH = 32,
    parameter int READ_LATENCY     = 1,
    localparam int BANDWIDTH = bandwidth(BLOCK_COUNT, BLOCK_DATA_WIDTH),
    localparam int AW        = aw(ADDRESS_DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [BANK_COUNT-1:0]             wr_en,
    input  logic [AW*BANK_COUNT-1:0]          wr_addr,
    input  logic [BANDWIDTH*BANK_COUNT-1:0]   wr_data,
    input  logic [BLOCK_COUNT*BANK_COUNT-1:0] wr_block_en,
    input  logic                              wr_commit,
    output logic                              wr_ready,
    output logic                              wr_drop,
    input  logic                              rd_en,
    input  logic [AW*BANK_COUNT-1:0]          rd_addr,
    input  logic                              rd_release,
    output logic                              rd_avail,
    output logic [BANDWIDTH*BANK_COUNT-1:0]   rd_data,
    output logic                              rd_valid
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ping_pong_bank_buffer: READ_LATENCY must be 1 or 2");
    end

    state_t state, next_state;
    logic   wr_sel;
    logic   swap;
    logic   commit_drop;
    logic   rd_acc;

    logic [READ_LATENCY-1:0]                     vld_pipe;
    logic [READ_LATENCY-1:0]                     sel_pipe;
    logic [1:0][BANDWIDTH*BANK_COUNT-1:0]        copy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            wr_sel  <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            state   <= next_state;
            if (swap) begin
                wr_sel <= ~wr_sel;
            end
            wr_drop <= ((|wr_en) & ~wr_ready) | commit_drop;
        end
    end

    always_comb begin
        next_state  = state;
        swap        = 1'b0;
        commit_drop = 1'b0;
        wr_ready    = (state != FULL_WAIT);
        rd_avail    = (state != EMPTY);
        unique case (state)
            EMPTY: begin
                if (wr_commit) begin
                    swap       = 1'b1;
                    next_state = READING;
                end
            end
            READING: begin
                if (wr_commit && rd_release) begin
                    swap = 1'b1;
                end else if (wr_commit) begin
                    next_state = FULL_WAIT;
                end else if (rd_release) begin
                    next_state = EMPTY;
                end
            end
            FULL_WAIT: begin
                // A commit here is dropped even if a release swaps in the same cycle.
                commit_drop = wr_commit;
                if (rd_release) begin
                    swap       = 1'b1;
                    next_state = READING;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    assign rd_acc = rd_en & rd_avail;

    // The read copy travels with the request so a swap mid-pipeline cannot redirect it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            sel_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc) begin
                sel_pipe[0] <= ~wr_sel;
            end
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) begin
                    sel_pipe[k] <= sel_pipe[k-1];
                end
            end
        end
    end

    assign rd_valid = vld_pipe[READ_LATENCY-1];

    for (genvar c = 0; c < 2; c++) begin : g_copy
        localparam logic COPY_ID = 1'(c);
        for (genvar i = 0; i < BANK_COUNT; i++) begin : g_bank
            bank_sdp_ram #(
                .DEPTH            (ADDRESS_DEPTH),
                .BLOCK_COUNT      (BLOCK_COUNT),
                .BLOCK_DATA_WIDTH (BLOCK_DATA_WIDTH),
                .READ_LATENCY     (READ_LATENCY)
            ) u_ram (
                .clk       (clk),
                .reset     (reset),
                .we        (wr_ready & wr_en[i] & (wr_sel == COPY_ID)),
                .waddr     (wr_addr[i*AW +: AW]),
                .wblock_en (wr_block_en[i*BLOCK_COUNT +: BLOCK_COUNT]),
                .wdata     (wr_data[i*BANDWIDTH +: BANDWIDTH]),
                .re        (rd_acc & (wr_sel != COPY_ID)),
                .raddr     (rd_addr[i*AW +: AW]),
                .rdata     (copy_q[c][i*BANDWIDTH +: BANDWIDTH])
            );
        end
    end

    always_comb begin
        rd_data = copy_q[sel_pipe[READ_LATENCY-1]];
    end

endmodule

// File: tb/tb_ping_pong_bank_buffer.sv
// Directed bench for ping_pong_bank_buffer. Two instances share all inputs:
// dut1 with READ_LATENCY=1, dut2 with READ_LATENCY=2.
module tb_ping_pong_bank_buffer;

    localparam int AD = 512;
    localparam int BK = 3;
    localparam int NB = 4;
    localparam int BD = 32;
    localparam int AW = 9;
    localparam int BW = NB * BD;
    localparam int DW = BW * BK;

    logic clk = 1'b0;
    logic reset;
    logic [BK-1:0]    wr_en;
    logic [AW*BK-1:0] wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NB*BK-1:0] wr_block_en;
    logic             wr_commit;
    logic             rd_en;
    logic [AW*BK-1:0] rd_addr;
    logic             rd_release;

    logic wr_ready1, wr_drop1, rd_avail1, rd_valid1;
    logic wr_ready2, wr_drop2, rd_avail2, rd_valid2;
    logic [DW-1:0] rd_data1, rd_data2;

    int n_vec = 0;
    int n_err = 0;

    logic v1a, v2a, v1b, v2b;
    logic [DW-1:0] d1, d1b, d2;

    always #5 clk = ~clk;

    ping_pong_bank_buffer #(
        .ADDRESS_DEPTH(AD), .BANK_COUNT(BK), .BLOCK_COUNT(NB),
        .BLOCK_DATA_WIDTH(BD), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_block_en(wr_block_en), .wr_commit(wr_commit), .wr_ready(wr_ready1),
        .wr_drop(wr_drop1), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail1), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    ping_pong_bank_buffer #(
        .ADDRESS_DEPTH(AD), .BANK_COUNT(BK), .BLOCK_COUNT(NB),
        .BLOCK_DATA_WIDTH(BD), .READ_LATENCY(2)
    ) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_block_en(wr_block_en), .wr_commit(wr_commit), .wr_ready(wr_ready2),
        .wr_drop(wr_drop2), .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail2), .rd_data(rd_data2), .rd_valid(rd_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_block_en = '0;
        wr_commit   = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        rd_release  = 1'b0;
    endtask

    task automatic set_write(input int bank, input logic [AW-1:0] addr,
                             input logic [BD-1:0] word, input logic [NB-1:0] blen);
        wr_en[bank]            = 1'b1;
        wr_addr[bank*AW +: AW] = addr;
        wr_data[bank*BW +: BW] = {NB{word}};
        wr_block_en[bank*NB +: NB] = blen;
    endtask

    // Issues one read (optionally with commit/release in the same cycle) and samples both DUTs.
    task automatic read_capture(input logic [AW-1:0] addr, input logic commit, input logic rel,
                                output logic o_v1a, output logic o_v2a,
                                output logic o_v1b, output logic o_v2b,
                                output logic [DW-1:0] o_d1, output logic [DW-1:0] o_d1b,
                                output logic [DW-1:0] o_d2);
        rd_en      = 1'b1;
        rd_addr    = {BK{addr}};
        wr_commit  = commit;
        rd_release = rel;
        tick();
        clear_inputs();
        o_v1a = rd_valid1;
        o_v2a = rd_valid2;
        o_d1  = rd_data1;
        tick();
        o_v1b = rd_valid1;
        o_v2b = rd_valid2;
        o_d1b = rd_data1;
        o_d2  = rd_data2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_vec++; if ({wr_ready1, wr_ready2} !== 2'b11) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 11", {wr_ready1, wr_ready2}); end
        n_vec++; if ({rd_avail1, rd_avail2} !== 2'b00) begin n_err++; $display("FAIL reset_rd_avail: got %b expected 00", {rd_avail1, rd_avail2}); end
        n_vec++; if ({rd_valid1, rd_valid2, wr_drop1, wr_drop2} !== 4'b0000) begin n_err++; $display("FAIL reset_valid_drop: got %b expected 0000", {rd_valid1, rd_valid2, wr_drop1, wr_drop2}); end
        n_vec++; if (rd_data1 !== '0 || rd_data2 !== '0) begin n_err++; $display("FAIL reset_rd_data: got %h / %h expected 0", rd_data1, rd_data2); end
        reset = 1'b0;
        tick();
        read_capture(9'd5, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if ({v1a, v2a, v1b, v2b} !== 4'b0000) begin n_err++; $display("FAIL empty_read_ignored: got %b expected 0000", {v1a, v2a, v1b, v2b}); end
        rd_release = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({rd_avail1, rd_avail2, wr_ready1, wr_ready2} !== 4'b0011) begin n_err++; $display("FAIL empty_release_ignored: got %b expected 0011", {rd_avail1, rd_avail2, wr_ready1, wr_ready2}); end
    endtask

    task automatic test_basic_frame();
        set_write(0, 9'd10, 32'hDEADBEEF, 4'hF);
        tick();
        clear_inputs();
        n_vec++; if ({rd_avail1, rd_avail2} !== 2'b00) begin n_err++; $display("FAIL basic_avail_before_commit: got %b expected 00", {rd_avail1, rd_avail2}); end
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({rd_avail1, rd_avail2, wr_ready1, wr_ready2} !== 4'b1111) begin n_err++; $display("FAIL basic_after_commit: got %b expected 1111", {rd_avail1, rd_avail2, wr_ready1, wr_ready2}); end
        read_capture(9'd10, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if ({v1a, v2a, v1b, v2b} !== 4'b1001) begin n_err++; $display("FAIL basic_valid_timing: got %b expected 1001", {v1a, v2a, v1b, v2b}); end
        n_vec++; if (d1[0 +: BW] !== {NB{32'hDEADBEEF}}) begin n_err++; $display("FAIL basic_data_lat1: got %h expected %h", d1[0 +: BW], {NB{32'hDEADBEEF}}); end
        n_vec++; if (d2[0 +: BW] !== {NB{32'hDEADBEEF}}) begin n_err++; $display("FAIL basic_data_lat2: got %h expected %h", d2[0 +: BW], {NB{32'hDEADBEEF}}); end
        n_vec++; if (d1b[0 +: BW] !== {NB{32'hDEADBEEF}}) begin n_err++; $display("FAIL basic_data_hold: got %h expected %h", d1b[0 +: BW], {NB{32'hDEADBEEF}}); end
        rd_release = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({rd_avail1, rd_avail2} !== 2'b00) begin n_err++; $display("FAIL basic_release_empty: got %b expected 00", {rd_avail1, rd_avail2}); end
    endtask

    task automatic test_block_mask();
        set_write(1, 9'd3, 32'hFFFFFFFF, 4'hF);
        tick();
        clear_inputs();
        set_write(1, 9'd3, 32'h00000000, 4'b0101);
        tick();
        clear_inputs();
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        read_capture(9'd3, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if (d1[BW +: BW] !== 128'hFFFFFFFF_00000000_FFFFFFFF_00000000) begin n_err++; $display("FAIL mask_data_lat1: got %h expected ffffffff00000000ffffffff00000000", d1[BW +: BW]); end
        n_vec++; if (d2[BW +: BW] !== 128'hFFFFFFFF_00000000_FFFFFFFF_00000000) begin n_err++; $display("FAIL mask_data_lat2: got %h expected ffffffff00000000ffffffff00000000", d2[BW +: BW]); end
        rd_release = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_full_wait();
        set_write(2, 9'd0, 32'h11111111, 4'hF);
        tick();
        clear_inputs();
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        set_write(2, 9'd0, 32'h22222222, 4'hF);
        tick();
        clear_inputs();
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({wr_ready1, wr_ready2, rd_avail1, rd_avail2} !== 4'b0011) begin n_err++; $display("FAIL full_wait_state: got %b expected 0011", {wr_ready1, wr_ready2, rd_avail1, rd_avail2}); end
        read_capture(9'd0, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if (d1[2*BW +: BW] !== {NB{32'h11111111}} || d2[2*BW +: BW] !== {NB{32'h11111111}}) begin n_err++; $display("FAIL full_wait_reader_frame1: got %h / %h expected %h", d1[2*BW +: BW], d2[2*BW +: BW], {NB{32'h11111111}}); end
        set_write(2, 9'd0, 32'h33333333, 4'hF);
        tick();
        clear_inputs();
        n_vec++; if ({wr_drop1, wr_drop2} !== 2'b11) begin n_err++; $display("FAIL write_drop_pulse: got %b expected 11", {wr_drop1, wr_drop2}); end
        tick();
        n_vec++; if ({wr_drop1, wr_drop2} !== 2'b00) begin n_err++; $display("FAIL write_drop_clears: got %b expected 00", {wr_drop1, wr_drop2}); end
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({wr_drop1, wr_drop2, wr_ready1, wr_ready2} !== 4'b1100) begin n_err++; $display("FAIL commit_drop_pulse: got %b expected 1100", {wr_drop1, wr_drop2, wr_ready1, wr_ready2}); end
        rd_release = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({wr_ready1, wr_ready2, rd_avail1, rd_avail2, wr_drop1, wr_drop2} !== 6'b111100) begin n_err++; $display("FAIL release_swap_state: got %b expected 111100", {wr_ready1, wr_ready2, rd_avail1, rd_avail2, wr_drop1, wr_drop2}); end
        read_capture(9'd0, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if (d1[2*BW +: BW] !== {NB{32'h22222222}} || d2[2*BW +: BW] !== {NB{32'h22222222}}) begin n_err++; $display("FAIL reader_frame2_unchanged: got %h / %h expected %h", d1[2*BW +: BW], d2[2*BW +: BW], {NB{32'h22222222}}); end
    endtask

    task automatic test_back_to_back();
        rd_release = 1'b1;
        tick();
        clear_inputs();
        // Write lands in the pre-swap copy even though commit is in the same cycle.
        set_write(0, 9'd7, 32'h5A5A0001, 4'hF);
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        set_write(0, 9'd7, 32'hC3C30002, 4'hF);
        tick();
        clear_inputs();
        read_capture(9'd7, 1'b1, 1'b1, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if ({v1a, v2a, v1b, v2b} !== 4'b1001) begin n_err++; $display("FAIL swap_read_timing: got %b expected 1001", {v1a, v2a, v1b, v2b}); end
        n_vec++; if (d1[0 +: BW] !== {NB{32'h5A5A0001}} || d2[0 +: BW] !== {NB{32'h5A5A0001}}) begin n_err++; $display("FAIL swap_read_old_copy: got %h / %h expected %h", d1[0 +: BW], d2[0 +: BW], {NB{32'h5A5A0001}}); end
        n_vec++; if ({rd_avail1, rd_avail2, wr_ready1, wr_ready2} !== 4'b1111) begin n_err++; $display("FAIL swap_stays_reading: got %b expected 1111", {rd_avail1, rd_avail2, wr_ready1, wr_ready2}); end
        read_capture(9'd7, 1'b0, 1'b0, v1a, v2a, v1b, v2b, d1, d1b, d2);
        n_vec++; if (d1[0 +: BW] !== {NB{32'hC3C30002}} || d2[0 +: BW] !== {NB{32'hC3C30002}}) begin n_err++; $display("FAIL swap_next_read_new: got %h / %h expected %h", d1[0 +: BW], d2[0 +: BW], {NB{32'hC3C30002}}); end
    endtask

    task automatic test_reset_mid();
        wr_commit = 1'b1;
        tick();
        clear_inputs();
        n_vec++; if ({wr_ready1, wr_ready2} !== 2'b00) begin n_err++; $display("FAIL mid_full_wait: got %b expected 00", {wr_ready1, wr_ready2}); end
        rd_en   = 1'b1;
        rd_addr = {BK{9'd7}};
        tick();
        clear_inputs();
        n_vec++; if ({rd_valid1, rd_valid2} !== 2'b10) begin n_err++; $display("FAIL mid_read_in_flight: got %b expected 10", {rd_valid1, rd_valid2}); end
        reset = 1'b1;
        tick();
        n_vec++; if ({rd_valid1, rd_valid2} !== 2'b00) begin n_err++; $display("FAIL mid_reset_flush: got %b expected 00", {rd_valid1, rd_valid2}); end
        n_vec++; if ({wr_ready1, wr_ready2, rd_avail1, rd_avail2} !== 4'b1100) begin n_err++; $display("FAIL mid_reset_state: got %b expected 1100", {wr_ready1, wr_ready2, rd_avail1, rd_avail2}); end
        n_vec++; if (rd_data1 !== '0 || rd_data2 !== '0) begin n_err++; $display("FAIL mid_reset_data: got %h / %h expected 0", rd_data1, rd_data2); end
        reset = 1'b0;
        tick();
        n_vec++; if ({rd_valid1, rd_valid2} !== 2'b00) begin n_err++; $display("FAIL mid_no_late_valid: got %b expected 00", {rd_valid1, rd_valid2}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_block_mask();
        test_full_wait();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ping_pong_bank_buffer.md
Name: ping_pong_bank_buffer

Overview:
Single-clock, double-buffered multi-bank line/frame store. It is a parametrised successor to the per-bank single buffer.
- Two full copies (A/B) of BANK_COUNT banks; the writer fills one copy while the reader drains the other.
- Ownership swaps on a commit/release handshake; per-block write masks and selectable read latency are added.
- Sits between the HDMI pixel packer (writer) and the matrix SPI output scheduler (reader).

Parameters:
ADDRESS_DEPTH, 512, words per bank per copy
BANK_COUNT, 3, independent banks (one per colour channel/segment)
BLOCK_COUNT, 4, blocks per bank word (write-mask granularity)
BLOCK_DATA_WIDTH, 32, bits per block
READ_LATENCY, 1, 1 = RAM output direct, 2 = extra output register; other values rejected by elaboration assertion
(derived) BANDWIDTH = BLOCK_COUNT*BLOCK_DATA_WIDTH; AW = $clog2(ADDRESS_DEPTH)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
wr_en  in  BANK_COUNT  per-bank write strobe
wr_addr  in  AW*BANK_COUNT  flat per-bank write address, bank i at [i*AW +: AW]
wr_data  in  BANDWIDTH*BANK_COUNT  flat write data
wr_block_en  in  BLOCK_COUNT*BANK_COUNT  per-block write mask
wr_commit  in  1  pulse: writer finished its copy
wr_ready  out  1  writer owns a free copy; writes accepted
wr_drop  out  1  one-cycle pulse: write or commit ignored
rd_en  in  1  read all banks at rd_addr
rd_addr  in  AW*BANK_COUNT  flat per-bank read address
rd_release  in  1  pulse: reader finished its copy
rd_avail  out  1  reader owns a committed copy
rd_data  out  BANDWIDTH*BANK_COUNT  flat read data
rd_valid  out  1  rd_data valid, READ_LATENCY cycles after accepted rd_en

Behaviour:
- Reset values: state EMPTY, wr_sel=0 (writer owns A), wr_ready=1, rd_avail=0, wr_drop=0, rd_valid=0, rd_data=0, read pipeline flushed. RAM contents are not cleared.
- Copy selection: write copy = wr_sel; read copy = ~wr_sel. A swap toggles wr_sel.
- FSM states:
  - EMPTY: rd_avail=0.
    - commit -> swap, READING.
    - release ignored.
  - READING: rd_avail=1, wr_ready=1.
    - commit & release in the same cycle -> swap, stay READING.
    - commit only -> FULL_WAIT.
    - release only -> EMPTY.
  - FULL_WAIT: wr_ready=0, rd_avail=1.
    - release -> swap, READING.
    - commit -> wr_drop.
- Writes:
  - A write is accepted when wr_ready=1 and wr_en[i]=1. Only blocks with wr_block_en set are updated.
  - A write issued in the commit cycle lands in the pre-swap copy (it is part of the committed frame).
  - Any wr_en bit set while wr_ready=0 -> write ignored, wr_drop=1 next cycle.
- Reads:
  - A read is accepted when rd_en=1 and rd_avail=1. rd_en while rd_avail=0 -> ignored, no rd_valid.
  - Copy select is captured with the address, so a read issued in the release cycle returns pre-swap data even though the swap happens mid-pipeline.
  - rd_data holds its last value when rd_valid=0.
- Same-address read/write cannot collide: the copies are disjoint.
- Registered outputs (wr_ready, rd_avail, wr_drop, rd_valid) update on the edge after the causing input.
- Reset mid-operation: the FSM and pipeline return to reset values on the next edge. A pending commit or release is lost.

Decomposition:
- Package ping_pong_pkg:
  - state enum {EMPTY, READING, FULL_WAIT}
  - function bandwidth(block_count, block_width)
  - localparam-friendly aw(depth) helper
- Sub-module bank_sdp_ram: single-clock simple dual-port RAM, one write port with block enables, one read port, optional output register. Instantiated 2*BANK_COUNT times.
- Top level holds the FSM, wr_sel, the read pipeline (valid/select shift) and the output mux.

Test Plan:
1. After reset, wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0. rd_en at addr 5 -> no rd_valid.
2. Write bank0 addr 10 = 0xDEADBEEF in all blocks, commit. Next cycle rd_avail=1. Read addr 10 -> rd_valid after READ_LATENCY (run with 1 and 2), bank0 data = 0xDEADBEEF in every block.
3. Write 0xFFFFFFFF to bank1 addr 3, then write 0x00000000 with wr_block_en=4'b0101, commit, read -> blocks 0/2 = 0, blocks 1/3 = 0xFFFFFFFF.
4. Commit twice without release -> state FULL_WAIT, wr_ready=0. A further write to addr 0 -> wr_drop pulse, memory unchanged. Release -> swap, wr_ready=1, reader sees the second frame.
5. Commit and release in the same cycle, plus rd_en at addr 7 that cycle -> returned data is from the old read copy; the next read returns the new frame.
6. Assert reset while in FULL_WAIT with a read in flight -> next cycle EMPTY, wr_ready=1, rd_avail=0, no rd_valid emerges.
